// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage and its environment: instruction
// memory port, hazard/redirect controls and the FD latch outputs.
interface fetch_stage_if;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc_plus_4;
  logic        fd_valid;

  modport master (
    output ihit, imemload, stall, redirect_en, redirect_pc, halt,
    input  imemREN, imemaddr, fd_instr, fd_pc_plus_4, fd_valid
  );

  modport slave (
    input  ihit, imemload, stall, redirect_en, redirect_pc, halt,
    output imemREN, imemaddr, fd_instr, fd_pc_plus_4, fd_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// Pipeline fetch stage: PC register, FD latch and a one-entry skid buffer that
// catches a word returned while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_stage_if.slave  fs
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] fd_instr_reg, fd_instr_next;
  logic [31:0] fd_pc_plus_4_reg, fd_pc_plus_4_next;
  logic        fd_valid_reg, fd_valid_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc_plus_4_reg, skid_pc_plus_4_next;
  logic [31:0] pc_plus_4;

  // Word alignment is enforced at every PC load so PC[1:0] stays zero.
  localparam logic [31:0] PC_RESET = PC_INIT & 32'hFFFF_FFFC;

  assign pc_plus_4 = pc_reg + 32'd4;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg          <= FETCH;
      pc_reg             <= PC_RESET;
      fd_instr_reg       <= '0;
      fd_pc_plus_4_reg   <= '0;
      fd_valid_reg       <= 1'b0;
      skid_instr_reg     <= '0;
      skid_pc_plus_4_reg <= '0;
    end else begin
      state_reg          <= state_next;
      pc_reg             <= pc_next;
      fd_instr_reg       <= fd_instr_next;
      fd_pc_plus_4_reg   <= fd_pc_plus_4_next;
      fd_valid_reg       <= fd_valid_next;
      skid_instr_reg     <= skid_instr_next;
      skid_pc_plus_4_reg <= skid_pc_plus_4_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    pc_next             = pc_reg;
    fd_instr_next       = fd_instr_reg;
    fd_pc_plus_4_next   = fd_pc_plus_4_reg;
    fd_valid_next       = fd_valid_reg;
    skid_instr_next     = skid_instr_reg;
    skid_pc_plus_4_next = skid_pc_plus_4_reg;

    if (state_reg != HALTED && fs.redirect_en) begin
      // Wrong-path fetch: the skid word is simply abandoned by leaving HOLD.
      state_next    = FETCH;
      pc_next       = fs.redirect_pc & 32'hFFFF_FFFC;
      fd_valid_next = 1'b0;
    end else if (state_reg != HALTED && fs.halt) begin
      state_next    = HALTED;
      fd_valid_next = 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (fs.ihit && fs.stall) begin
            skid_instr_next     = fs.imemload;
            skid_pc_plus_4_next = pc_plus_4;
            pc_next             = pc_plus_4;
            state_next          = HOLD;
          end else if (fs.ihit) begin
            fd_instr_next     = fs.imemload;
            fd_pc_plus_4_next = pc_plus_4;
            fd_valid_next     = 1'b1;
            pc_next           = pc_plus_4;
          end else if (!fs.stall) begin
            fd_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (!fs.stall) begin
            fd_instr_next     = skid_instr_reg;
            fd_pc_plus_4_next = skid_pc_plus_4_reg;
            fd_valid_next     = 1'b1;
            state_next        = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign fs.imemREN      = (state_reg == FETCH);
  assign fs.imemaddr     = pc_reg;
  assign fs.fd_instr     = fd_instr_reg;
  assign fs.fd_pc_plus_4 = fd_pc_plus_4_reg;
  assign fs.fd_valid     = fd_valid_reg;

endmodule
